// File: rtl/btn_event_scheduler.sv
// btn_event_scheduler: synchronizes N_BTN raw active-low buttons and, using a
// single shared counter, debounces one button at a time. Each accepted press
// is offered as one event on a valid/ready handshake. Buttons are picked
// round-robin, starting at the index after the last button served.
// Optional feature: define BTN_AUTO_REPEAT_EN to re-issue the event every
// REPEAT_CYC cycles while the button stays held after the handshake.

module btn_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d_n,
  output logic q_n
);
  logic meta_n;

  // two-flop synchronizer; resets to the released level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_n <= 1'b1;
      q_n    <= 1'b1;
    end else begin
      meta_n <= d_n;
      q_n    <= meta_n;
    end
  end
endmodule

module btn_event_scheduler #(
  parameter int              N_BTN      = 4,
  parameter int              CNT_W      = 24,
  parameter logic [CNT_W-1:0] PRESS_CYC  = 24'hFF1000,
  parameter logic [CNT_W-1:0] REL_CYC    = 24'h0FFFFF,
  parameter logic [CNT_W-1:0] REPEAT_CYC = 24'hFFFFFF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_BTN-1:0]         btn_n,
  input  logic                     evt_ready,
  output logic                     evt_valid,
  output logic [$clog2(N_BTN)-1:0] evt_id,
  output logic                     busy
);
  localparam int ID_W = $clog2(N_BTN);
  localparam logic [CNT_W-1:0] PRESS_LAST = PRESS_CYC - 1'b1;
  localparam logic [CNT_W-1:0] REL_LAST   = REL_CYC - 1'b1;

  typedef enum logic [1:0] {IDLE, PRESS, PEND, RELEASE} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [ID_W-1:0]  sel;
  logic [ID_W-1:0]  rr_ptr;
  logic [ID_W-1:0]  sel_nxt;
  logic [N_BTN-1:0] sb;
  logic             pick_hit;
  logic [ID_W-1:0]  pick_idx;

`ifdef BTN_AUTO_REPEAT_EN
  localparam logic [CNT_W-1:0] REP_LAST = REPEAT_CYC - 1'b1;
  logic rel_hi;  // level of sb[sel] seen on the previous RELEASE cycle
`else
  logic unused_repeat;
  assign unused_repeat = ^REPEAT_CYC;
`endif

  btn_sync2 u_sync [N_BTN-1:0] (.clk(clk), .rst_n(rst_n), .d_n(btn_n), .q_n(sb));

  assign sel_nxt = (sel == ID_W'(N_BTN - 1)) ? '0 : sel + 1'b1;

  // first pressed button at or above rr_ptr, wrapping; scanning downward lets
  // the smallest offset win
  always_comb begin
    int              j;
    logic [ID_W-1:0] idx;
    pick_hit = 1'b0;
    pick_idx = '0;
    j        = 0;
    idx      = '0;
    for (int i = N_BTN - 1; i >= 0; i--) begin
      j = int'(rr_ptr) + i;
      if (j >= N_BTN) j = j - N_BTN;
      idx = ID_W'(j);
      if (!sb[idx]) begin
        pick_hit = 1'b1;
        pick_idx = idx;
      end
    end
  end

  // scheduler FSM with registered handshake and busy outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      sel       <= '0;
      rr_ptr    <= '0;
      evt_valid <= 1'b0;
      evt_id    <= '0;
      busy      <= 1'b0;
`ifdef BTN_AUTO_REPEAT_EN
      rel_hi    <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          cnt <= '0;
          if (pick_hit) begin
            sel   <= pick_idx;
            state <= PRESS;
            busy  <= 1'b1;
          end
        end
        PRESS: begin
          if (sb[sel]) begin
            // bounce: give up without touching rr_ptr
            state <= IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
          end else if (cnt == PRESS_LAST) begin
            state     <= PEND;
            cnt       <= '0;
            evt_valid <= 1'b1;
            evt_id    <= sel;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        PEND: begin
          // event is held regardless of the button level until taken
          if (evt_ready) begin
            state     <= RELEASE;
            cnt       <= '0;
            evt_valid <= 1'b0;
`ifdef BTN_AUTO_REPEAT_EN
            rel_hi    <= 1'b0;
`endif
          end
        end
        RELEASE: begin
`ifdef BTN_AUTO_REPEAT_EN
          rel_hi <= sb[sel];
          if (sb[sel] != rel_hi) begin
            cnt <= '0;
          end else if (sb[sel]) begin
            if (cnt == REL_LAST) begin
              state  <= IDLE;
              cnt    <= '0;
              busy   <= 1'b0;
              rr_ptr <= sel_nxt;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end else if (cnt == REP_LAST) begin
            state     <= PEND;
            cnt       <= '0;
            evt_valid <= 1'b1;
            evt_id    <= sel;
          end else begin
            cnt <= cnt + 1'b1;
          end
`else
          if (!sb[sel]) begin
            cnt <= '0;
          end else if (cnt == REL_LAST) begin
            state  <= IDLE;
            cnt    <= '0;
            busy   <= 1'b0;
            rr_ptr <= sel_nxt;
          end else begin
            cnt <= cnt + 1'b1;
          end
`endif
        end
      endcase
    end
  end
endmodule

// File: tb/tb_btn_event_scheduler.sv
// Bench for btn_event_scheduler with PRESS_CYC=8, REL_CYC=4, REPEAT_CYC=16.
module tb_btn_event_scheduler;
  localparam int N   = 4;
  localparam int PC  = 8;
  localparam int RC  = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] btn_n = '1;
  logic         evt_ready = 1'b0;
  logic         evt_valid;
  logic [1:0]   evt_id;
  logic         busy;

  int errors = 0;
  int checks = 0;
  int m_rr   = 0;   // model of the round-robin start index

  btn_event_scheduler #(
    .N_BTN(N), .CNT_W(24), .PRESS_CYC(24'd8), .REL_CYC(24'd4), .REPEAT_CYC(24'd16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .btn_n(btn_n), .evt_ready(evt_ready),
    .evt_valid(evt_valid), .evt_id(evt_id), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

  typedef struct {
    logic [N-1:0] btn;
    logic         rdy;
    logic         v;
    logic [1:0]   id;
    logic         b;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input int n, input logic [N-1:0] btn, input logic rdy,
                     input logic v, input logic [1:0] id, input logic b);
    vec_t r;
    r.btn = btn; r.rdy = rdy; r.v = v; r.id = id; r.b = b;
    repeat (n) tbl.push_back(r);
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    btn_n = '1;
    evt_ready = 1'b0;
    rst_n = 1'b0;
    tick(); tick();
    check("rst_valid", evt_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_id", evt_id, 0);
    rst_n = 1'b1;
    tick(); tick();
    m_rr = 0;
  endtask

  // Hold the buttons in mask low together; each is released right after its
  // event is taken. Events must come in cyclic order starting at m_rr.
  task automatic run_multi(input logic [N-1:0] mask, input int dmax, output int first_id);
    int exp_q[$];
    int n;
    int d;
    for (int i = 0; i < N; i++)
      if (mask[(m_rr + i) % N]) exp_q.push_back((m_rr + i) % N);
    first_id = -1;
    btn_n = ~mask;
    foreach (exp_q[e]) begin
      n = 0;
      while (!evt_valid && n < 60) begin tick(); n++; end
      check("evt_seen", evt_valid, 1);
      check(e == 0 ? "press_lat" : "gap_lat", n, e == 0 ? PC + 3 : RC + PC + 3);
      check("evt_id", evt_id, exp_q[e]);
      if (e == 0) first_id = evt_id;
      d = $urandom_range(0, dmax);
      repeat (d) tick();
      check("hold_valid", evt_valid, 1);
      check("hold_id", evt_id, exp_q[e]);
      evt_ready = 1'b1;
      tick();
      evt_ready = 1'b0;
      check("accept_drop", evt_valid, 0);
      btn_n[exp_q[e]] = 1'b1;
    end
    n = 0;
    while (busy && n < 40) begin tick(); n++; end
    check("idle_lat", n, RC + 2);
    m_rr = (exp_q[exp_q.size() - 1] + 1) % N;
    tick(); tick();
  endtask

  task automatic run_bounce(input int b, input int d);
    int hits;
    hits = 0;
    btn_n[b] = 1'b0;
    repeat (d) begin tick(); if (evt_valid) hits++; end
    btn_n[b] = 1'b1;
    repeat (20) begin tick(); if (evt_valid) hits++; end
    check("bounce_noevt", hits, 0);
    check("bounce_idle", busy, 0);
  endtask

  initial begin
    int fid;
    int bad;
    int n;
    int evts;

    // short press on button 1: rejected, back to IDLE
    add(2, 4'b1101, 1'b0, 1'b0, 2'd0, 1'b0);
    add(3, 4'b1101, 1'b0, 1'b0, 2'd0, 1'b1);
    add(2, 4'b1111, 1'b0, 1'b0, 2'd0, 1'b1);
    add(3, 4'b1111, 1'b0, 1'b0, 2'd0, 1'b0);
    // button 2 held with ready high: one-cycle event after edge k+10
    add(2, 4'b1011, 1'b1, 1'b0, 2'd0, 1'b0);
    add(8, 4'b1011, 1'b1, 1'b0, 2'd0, 1'b1);
    add(1, 4'b1011, 1'b1, 1'b1, 2'd2, 1'b1);
    add(1, 4'b1011, 1'b1, 1'b0, 2'd0, 1'b1);
    add(5, 4'b1111, 1'b1, 1'b0, 2'd0, 1'b1);
    add(3, 4'b1111, 1'b1, 1'b0, 2'd0, 1'b0);

    #1;
    check("rst0_valid", evt_valid, 0);
    check("rst0_busy", busy, 0);
    do_reset();

    foreach (tbl[i]) begin
      btn_n = tbl[i].btn;
      evt_ready = tbl[i].rdy;
      tick();
      check($sformatf("tbl%0d_valid", i), evt_valid, tbl[i].v);
      check($sformatf("tbl%0d_busy", i), busy, tbl[i].b);
      if (tbl[i].v) check($sformatf("tbl%0d_id", i), evt_id, tbl[i].id);
    end
    evt_ready = 1'b0;

    // buttons 0 and 3 together, twice: 0 then 3 each time
    do_reset();
    run_multi(4'b1001, 0, fid);
    check("rr_first_a", fid, 0);
    run_multi(4'b1001, 0, fid);
    check("rr_first_b", fid, 0);

    // ready held low in PEND with the button released
    btn_n = 4'b1101;
    n = 0;
    while (!evt_valid && n < 40) begin tick(); n++; end
    check("stall_seen", evt_valid, 1);
    btn_n = '1;
    bad = 0;
    repeat (20) begin
      tick();
      if (!evt_valid || evt_id != 2'd1) bad++;
    end
    check("stall_stable", bad, 0);
    evt_ready = 1'b1;
    tick();
    evt_ready = 1'b0;
    check("stall_taken", evt_valid, 0);
    tick(); tick(); tick();
    check("stall_rel_busy", busy, 1);
    tick();
    check("stall_rel_idle", busy, 0);
    m_rr = 2;
    tick();

    // reset while an event is pending
    btn_n = 4'b1011;
    n = 0;
    while (!evt_valid && n < 40) begin tick(); n++; end
    check("rstpend_seen", evt_valid, 1);
    btn_n = '1;
    #2 rst_n = 1'b0;
    #1;
    check("rstpend_valid", evt_valid, 0);
    check("rstpend_busy", busy, 0);
    tick(); tick();
    rst_n = 1'b1;
    m_rr = 0;
    evts = 0;
    repeat (30) begin tick(); if (evt_valid) evts++; end
    check("rstpend_noevt", evts, 0);

    // button held well past its event
    btn_n = 4'b1110;
    evt_ready = 1'b1;
    evts = 0;
    repeat (PC + 3 + 60) begin tick(); if (evt_valid) evts++; end
`ifdef BTN_AUTO_REPEAT_EN
    check("held_repeats", int'(evts > 1), 1);
`else
    check("held_one_evt", evts, 1);
`endif
    btn_n = '1;
    evt_ready = 1'b0;
    repeat (40) tick();
    check("held_idle", busy, 0);

    // randomized trials against the round-robin model
    do_reset();
    for (int t = 0; t < 16; t++) begin
      if ($urandom_range(0, 2) == 0)
        run_bounce($urandom_range(0, N - 1), $urandom_range(1, 6));
      else
        run_multi(N'($urandom_range(1, (1 << N) - 1)), 3, fid);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
